// File: rtl/detector_scheduler.sv
// detector_scheduler: round-robin owner of one shared serial sequence detector.
// Each grant clears the detector, streams FRAME_LEN bits from the owner into x,
// counts F over the response window, then reports {owner id, hit count}.
// Every output is a register loaded from next-state values, so the detector and
// the requesters only ever see glitch-free, edge-aligned signals.
module detector_scheduler #(
  parameter int NREQ      = 4,
  parameter int FRAME_LEN = 8,
  localparam int IDW      = $clog2(NREQ),
  localparam int CW       = $clog2(FRAME_LEN + 1)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] bit_in,
  input  logic            F,
  output logic            x,
  output logic            det_clr,
  output logic [NREQ-1:0] grant,
  output logic            bit_ack,
  output logic            busy,
  output logic            done,
  output logic [IDW-1:0]  done_id,
  output logic [CW-1:0]   hit_cnt
);

  localparam int             BW       = $clog2(FRAME_LEN);
  localparam logic [BW-1:0]  LAST_BIT = BW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]  HIT_MAX  = CW'(FRAME_LEN);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   hit_q, hit_d;
  logic            x_q, x_d;
  logic            det_clr_q, det_clr_d;
  logic            bit_ack_q, bit_ack_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IDW-1:0]  done_id_q, done_id_d;
  logic [CW-1:0]   hit_cnt_q, hit_cnt_d;

  logic [IDW-1:0]  win_idx;
  logic [CW-1:0]   hit_inc;

  // Saturating increment of the hit counter.
  assign hit_inc = (hit_q == HIT_MAX) ? hit_q : hit_q + 1'b1;

  // Rotating-priority pick: scan downward so the last hit is the first set bit at or above rr_q.
  always_comb begin
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_q) + i) % NREQ]) win_idx = IDW'((int'(rr_q) + i) % NREQ);
    end
  end

  // Next-state and next-output logic of the frame sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave one unassigned (no latches).
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    bit_cnt_d = bit_cnt_q;
    hit_d     = hit_q;
    x_d       = 1'b0;
    det_clr_d = 1'b0;
    bit_ack_d = 1'b0;
    done_d    = 1'b0;
    done_id_d = '0;
    hit_cnt_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req != '0) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          det_clr_d        = 1'b1;
          state_d          = S_CLEAR;
        end
      end
      S_CLEAR: begin
        bit_cnt_d = '0;
        hit_d     = '0;
        x_d       = bit_in[owner_q];
        bit_ack_d = 1'b1;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        // F in the first streamed cycle still reflects the cleared detector.
        if (F && (bit_cnt_q != '0)) hit_d = hit_inc;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = S_FLUSH;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          x_d       = bit_in[owner_q];
          bit_ack_d = 1'b1;
        end
      end
      S_FLUSH: begin
        // Detector response to the final bit arrives here.
        if (F) hit_d = hit_inc;
        done_d    = 1'b1;
        done_id_d = owner_q;
        hit_cnt_d = hit_d;
        grant_d   = '0;
        rr_d      = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      bit_cnt_q <= '0;
      hit_q     <= '0;
      x_q       <= 1'b0;
      det_clr_q <= 1'b0;
      bit_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register see pre-edge values of the others.
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      bit_cnt_q <= bit_cnt_d;
      hit_q     <= hit_d;
      x_q       <= x_d;
      det_clr_q <= det_clr_d;
      bit_ack_q <= bit_ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign x       = x_q;
  assign det_clr = det_clr_q;
  assign grant   = grant_q;
  assign bit_ack = bit_ack_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_detector_scheduler.sv
// Directed bench for detector_scheduler (NREQ=4, FRAME_LEN=8). A "101" Moore
// detector model drives F from the scheduler's x/det_clr; serial sources feed
// bit_in MSB-first from per-requester patterns, advancing on bit_ack.
module tb_detector_scheduler;

  localparam int NREQ = 4;
  localparam int FL   = 8;

  logic       CLK    = 1'b0;
  logic       RESET  = 1'b0;
  logic [3:0] req    = '0;
  logic [3:0] bit_in = '0;
  logic       F;
  logic       x, det_clr, bit_ack, busy, done;
  logic [3:0] grant;
  logic [1:0] done_id;
  logic [3:0] hit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pat [4];
  logic [2:0] det_q;
  logic       force_en  = 1'b0;
  logic       force_val = 1'b0;

  detector_scheduler #(.NREQ(NREQ), .FRAME_LEN(FL)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .bit_in(bit_in), .F(F),
    .x(x), .det_clr(det_clr), .grant(grant), .bit_ack(bit_ack), .busy(busy),
    .done(done), .done_id(done_id), .hit_cnt(hit_cnt)
  );

  always #5 CLK = ~CLK;

  // "101" overlapping detector: S0 none, S1 "1", S2 "10", S3 "101" (F=1).
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) det_q <= 3'd0;
    else if (det_clr) det_q <= 3'd0;
    else begin
      case (det_q)
        3'd0:    det_q <= x ? 3'd1 : 3'd0;
        3'd1:    det_q <= x ? 3'd1 : 3'd2;
        3'd2:    det_q <= x ? 3'd3 : 3'd0;
        default: det_q <= x ? 3'd1 : 3'd2;
      endcase
    end
  end
  assign F = force_en ? force_val : (det_q == 3'd3);

  // Monitor plus serial sources, sampled on the falling edge.
  int cyc = 0, n_ack = 0, n_clr = 0, n_done = 0, x_bad = 0, onehot_bad = 0;
  int sidx = 0, mon_owner = 0, clr_cyc = 0, done_cyc = 0, last_lat = 0, last_gap = 0;
  logic [1:0] last_id  = '0;
  logic [3:0] last_cnt = '0;

  always @(negedge CLK) begin
    if (det_clr) begin
      mon_owner = 0;
      for (int i = 0; i < NREQ; i++) if (grant[i]) mon_owner = i;
      sidx = 0;
      bit_in[mon_owner] = pat[mon_owner][FL-1];
      n_clr++;
      last_gap = cyc - done_cyc;
      clr_cyc  = cyc;
    end
    if (bit_ack) begin
      if (sidx >= FL) x_bad++;
      else if (x !== pat[mon_owner][FL-1-sidx]) x_bad++;
      sidx++;
      n_ack++;
      if (sidx < FL) bit_in[mon_owner] = pat[mon_owner][FL-1-sidx];
    end
    if (grant != '0 && !$onehot(grant)) onehot_bad++;
    if (done) begin
      n_done++;
      last_id  = done_id;
      last_cnt = hit_cnt;
      last_lat = cyc - clr_cyc;
      done_cyc = cyc;
    end
    cyc++;
  end

  task automatic wait_done(input int budget, output bit ok);
    int start = n_done;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK); #1;
      if (n_done != start) ok = 1'b1;
    end
  endtask

  task automatic wait_clr(input int budget, output bit ok);
    int start = n_clr;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK); #1;
      if (n_clr != start) ok = 1'b1;
    end
  endtask

  task automatic wait_acks(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK); #1;
      if (n_ack >= target) ok = 1'b1;
    end
  endtask

  // Waits for one frame and checks its id and hit count.
  task automatic frame_expect(input string name, input logic [1:0] exp_id, input logic [3:0] exp_cnt);
    bit ok;
    wait_done(40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL %s timeout: no done within 40 cycles", name);
    end
    n_checks++;
    if (last_id !== exp_id) begin
      n_fail++; $display("FAIL %s done_id: got %0d expected %0d", name, last_id, exp_id);
    end
    n_checks++;
    if (last_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL %s hit_cnt: got %0d expected %0d", name, last_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({x, det_clr, grant, bit_ack, busy, done, done_id, hit_cnt} !== 15'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0",
                         {x, det_clr, grant, bit_ack, busy, done, done_id, hit_cnt});
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    n_checks++;
    if (busy !== 1'b0 || grant !== 4'd0) begin
      n_fail++; $display("FAIL idle_no_req: busy=%b grant=%b expected 0/0000", busy, grant);
    end
  endtask

  task automatic test_single;
    bit ok;
    int ack0, clr0;
    req = 4'b0100;
    wait_clr(5, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_clr timeout: no det_clr in 5 cycles"); end
    n_checks++;
    if (grant !== 4'b0100 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_grant: grant=%b busy=%b expected 0100/1", grant, busy);
    end
    req  = 4'b0000;
    ack0 = n_ack;
    clr0 = n_clr;
    frame_expect("single", 2'd2, 4'd2);
    n_checks++;
    if (n_ack - ack0 !== 8) begin
      n_fail++; $display("FAIL single_acks: got %0d expected 8", n_ack - ack0);
    end
    n_checks++;
    if (n_clr !== clr0) begin
      n_fail++; $display("FAIL single_clr_width: extra det_clr cycles %0d expected 0", n_clr - clr0);
    end
    n_checks++;
    if (last_lat !== 10) begin
      n_fail++; $display("FAIL single_latency: clear-to-done %0d expected 10", last_lat);
    end
    n_checks++;
    if (grant !== 4'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL done_state: grant=%b busy=%b expected 0000/1", grant, busy);
    end
    @(negedge CLK); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL after_done: busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_wrap;
    req = 4'b1000;
    frame_expect("wrap_r3", 2'd3, 4'd2);
    req = 4'b1001;
    frame_expect("wrap_a", 2'd0, 4'd2);
    frame_expect("wrap_b", 2'd3, 4'd2);
    frame_expect("wrap_c", 2'd0, 4'd2);
    req = 4'b0000;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_abort;
    bit ok;
    int d0;
    req = 4'b0010;
    wait_clr(5, ok);
    req = 4'b0000;
    wait_acks(n_ack + 3, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL abort_stream timeout: 3 acks not seen"); end
    d0 = n_done;
    #2 RESET = 1'b0;
    #1;
    n_checks++;
    if ({x, det_clr, grant, bit_ack, busy, done, done_id, hit_cnt} !== 15'd0) begin
      n_fail++; $display("FAIL abort_outputs: got %h expected 0",
                         {x, det_clr, grant, bit_ack, busy, done, done_id, hit_cnt});
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (12) @(negedge CLK);
    #1;
    n_checks++;
    if (n_done !== d0) begin
      n_fail++; $display("FAIL abort_no_done: done pulses %0d expected 0", n_done - d0);
    end
  endtask

  task automatic test_round_robin;
    req = 4'b1111;
    frame_expect("rr_0", 2'd0, 4'd2);
    frame_expect("rr_1", 2'd1, 4'd2);
    n_checks++;
    if (last_gap !== 2) begin
      n_fail++; $display("FAIL back_to_back_gap: done-to-clear %0d expected 2", last_gap);
    end
    frame_expect("rr_2", 2'd2, 4'd2);
    frame_expect("rr_3", 2'd3, 4'd2);
    frame_expect("rr_4", 2'd0, 4'd2);
    req = 4'b0000;
    n_checks++;
    if (onehot_bad !== 0) begin
      n_fail++; $display("FAIL grant_onehot: violations %0d expected 0", onehot_bad);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_req_drop;
    bit ok;
    int ack0;
    req = 4'b0010;
    wait_clr(5, ok);
    ack0 = n_ack;
    wait_acks(ack0 + 3, 20, ok);
    req = 4'b0100;
    frame_expect("drop_owner", 2'd1, 4'd2);
    n_checks++;
    if (n_ack - ack0 !== 8) begin
      n_fail++; $display("FAIL drop_acks: got %0d expected 8", n_ack - ack0);
    end
    frame_expect("drop_waiter", 2'd2, 4'd2);
    req = 4'b0000;
    n_checks++;
    if (last_gap !== 2) begin
      n_fail++; $display("FAIL drop_gap: done-to-clear %0d expected 2", last_gap);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_count_boundary;
    bit ok;
    force_en  = 1'b1;
    force_val = 1'b1;
    req = 4'b0001;
    wait_clr(5, ok);
    req = 4'b0000;
    frame_expect("f_high", 2'd0, 4'd8);
    repeat (2) @(negedge CLK);
    force_val = 1'b0;
    req = 4'b0001;
    wait_clr(5, ok);
    req = 4'b0000;
    frame_expect("f_low", 2'd0, 4'd0);
    repeat (2) @(negedge CLK);
    // F high only through CLEAR and the first streamed cycle: none of it counts.
    force_val = 1'b1;
    req = 4'b0001;
    wait_clr(5, ok);
    req = 4'b0000;
    @(posedge CLK);
    @(posedge CLK);
    #1 force_val = 1'b0;
    frame_expect("f_early", 2'd0, 4'd0);
    force_en = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) pat[i] = 8'b10110110;
    test_reset();
    test_single();
    test_wrap();
    test_reset_abort();
    test_round_robin();
    test_req_drop();
    test_count_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/detector_scheduler.md
Name: detector_scheduler

Overview:
- Round-robin scheduler that time-shares one serial sequence-detector FSM among NREQ serial requesters.
- Detector interface: 1-bit input x, output F, 3-bit state.
- Per granted requester:
  - clears the detector,
  - streams exactly FRAME_LEN bits from that requester into x,
  - counts the cycles in which F is asserted,
  - reports the count with the requester id, then re-arbitrates.
- Sits between the serial front-end channels and the shared detector instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- FRAME_LEN, 8, bits streamed per grant (2..255)
- IDW, derived = $clog2(NREQ), width of requester id
- CW, derived = $clog2(FRAME_LEN+1), width of hit count

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset (0 = reset)
- req  in  NREQ  per-requester frame request, level
- bit_in  in  NREQ  per-requester serial data bit
- F  in  1  detector output
- x  out  1  detector serial input
- det_clr  out  1  detector clear, active-high, one cycle
- grant  out  NREQ  one-hot current owner; 0 when idle
- bit_ack  out  1  high in each cycle bit_in[owner] is consumed
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- done_id  out  IDW  owner id, valid while done=1
- hit_cnt  out  CW  F-count for frame, valid while done=1

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE; rr_ptr=0; bit counter=0; hit counter=0.
  - Outputs: x=0, det_clr=0, grant=0, bit_ack=0, busy=0, done=0, done_id=0, hit_cnt=0.
  - Deassertion is taken at the next CLK edge.
  - Reset mid-frame aborts the frame: no done pulse, no pointer update.
- States: IDLE, CLEAR, STREAM, FLUSH, DONE. All outputs are registered.
- IDLE:
  - If req!=0, choose the winner: first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Latch winner into grant and owner id; go to CLEAR.
  - If req==0, stay in IDLE.
- CLEAR (1 cycle):
  - det_clr=1, x=0.
  - Clear bit and hit counters; go to STREAM.
- STREAM (exactly FRAME_LEN cycles):
  - x = bit_in[owner], sampled combinationally into the x register so it is valid in the cycle it is consumed.
  - bit_ack=1 in each STREAM cycle.
  - From the 2nd STREAM cycle onward, F=1 increments the hit counter.
  - After the FRAME_LEN-th cycle go to FLUSH.
- FLUSH (1 cycle):
  - x=0, bit_ack=0.
  - F=1 increments the hit counter; this captures the response to the last bit.
  - Go to DONE.
  - Net count window = FRAME_LEN cycles: STREAM cycles 2..FRAME_LEN plus FLUSH.
- DONE (1 cycle):
  - done=1; done_id=owner; hit_cnt=hit counter.
  - rr_ptr = (owner+1) mod NREQ; grant=0; go to IDLE.
- Latency:
  - req to first bit_ack = 2 cycles (IDLE, CLEAR).
  - Frame start to done = FRAME_LEN+3 cycles.
  - Back-to-back frames have 1 IDLE cycle between DONE and the next CLEAR.
- req is sampled only in IDLE:
  - Deasserting the owner's req mid-frame does not abort; the full frame is streamed.
  - New requests during busy wait for IDLE.
- Simultaneous requests: rotating priority. A continuously-asserting requester cannot win twice while another requester is waiting.
- Hit counter saturates at FRAME_LEN; it cannot exceed FRAME_LEN by construction.
- grant is held constant and one-hot for CLEAR..FLUSH; 0 in IDLE and DONE.

Test Plan:
- Reset:
  - Assert RESET=0 mid-STREAM → all outputs 0 immediately.
  - Release → IDLE; next req=0001 grants requester 0 (rr_ptr back to 0).
  - No done pulse for the aborted frame.
- Single requester, FRAME_LEN=8:
  - req=0100, bit_in[2]=10110110 with a detector model.
  - Required: det_clr pulse 1 cycle; 8 bit_ack cycles with x matching the sequence.
  - done at cycle 11 after the grant cycle, done_id=2, hit_cnt = model's F count.
- Round-robin:
  - req=1111 held continuously for 4 frames → done_id sequence 0,1,2,3.
  - Then 0 again; grant always one-hot.
- Wrap:
  - After requester 3 completes, req=1001 → requester 0 wins (pointer wrap).
  - Then requester 3, then 0.
- Mid-frame req drop:
  - Owner drops req after 3 bits → still 8 bit_ack, done issued.
  - req raised by another requester mid-frame is served after DONE+IDLE.
- Counting boundary:
  - F forced high every cycle → hit_cnt=8 (F ignored in CLEAR and the first STREAM cycle, counted in FLUSH).
  - F forced low → hit_cnt=0.
